// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 configuration sequencer.
// Holds the sequencer state encoding, ROM entry-format constants, and the
// COM7 soft-reset prologue constants used when OV7670_SOFT_RESET_EN is defined.
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WAIT_IDLE   = 4'd1,
    S_FETCH       = 4'd2,
    S_DECODE      = 4'd3,
    S_ISSUE       = 4'd4,
    S_WAIT_ACCEPT = 4'd5,
    S_WAIT_DONE   = 4'd6,
    S_DELAY       = 4'd7,
    S_FINISH      = 4'd8
  } cfg_state_t;

  // ROM entry format: {hi,lo}
  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_TAG = 8'hF0;

  // COM7 register and its soft-reset value
  localparam logic [7:0]  COM7_ADDR       = 8'h12;
  localparam logic [7:0]  COM7_SOFT_RESET = 8'h80;

  // Settling time after a soft reset, in milliseconds
  localparam logic [7:0]  SOFT_RESET_MS   = 8'd10;

endpackage

// File: rtl/ov7670_config_rom.sv
// OV7670 register table: ROM_DEPTH x 16 synchronous ROM, 1-cycle read latency.
// Entries are {reg,value} writes, {F0,ms} delays, or FFFF end marker.
// Unlisted addresses hold the end marker. Swap this file per camera mode.
// Ports:
//   clk   - clock
//   addr  - entry index
//   data  - entry registered on the clock after addr is presented
module ov7670_config_rom #(
  parameter int unsigned ROM_DEPTH = 128,
  parameter int unsigned ROM_AW    = 7
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  function automatic logic [15:0] rom_entry(input int unsigned idx);
    logic [15:0] e;
    case (idx)
      0:       e = 16'h3A04; // TSLB
      1:       e = 16'h40D0; // COM15: RGB565, full range
      2:       e = 16'h1214; // COM7: QVGA, RGB
      3:       e = 16'h8C00; // RGB444 off
      4:       e = 16'hF002; // wait 2 ms
      5:       e = 16'h1716; // HSTART
      6:       e = 16'hF000; // zero-length delay
      7:       e = 16'h1804; // HSTOP
      8:       e = 16'h3224; // HREF
      9:       e = 16'h1902; // VSTRT
      10:      e = 16'h1A7A; // VSTOP
      11:      e = 16'h030A; // VREF
      default: e = 16'hFFFF;
    endcase
    return e;
  endfunction

  always_ff @(posedge clk) begin
    data <= rom_entry(int'(addr));
  end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks the register ROM and hands each
// {address,data} pair to the SCCB write engine over a start/ready handshake,
// executes embedded millisecond delays, stops at the end marker (or the last
// ROM entry) and raises a sticky done.
// Optional feature macro: OV7670_SOFT_RESET_EN - prefix every pass with a
// COM7 soft-reset write followed by a 10 ms settling delay.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   cfg_start     - pulse: start a pass from entry 0 (ignored while busy)
//   sccb_ready    - SCCB engine idle
//   sccb_start    - one-cycle write request
//   sccb_address  - register address, held for the whole write
//   sccb_data     - register value, held for the whole write
//   busy          - pass in progress
//   done          - sticky end-of-pass flag
//   rom_index     - ROM entry being processed
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned ROM_DEPTH  = 128,
  parameter int unsigned ROM_AW     = 7,
  parameter int unsigned AUTO_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_index
);

  localparam int unsigned TICKS  = CLK_FREQ / 1000;
  localparam int unsigned TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  cfg_state_t        state;
  cfg_state_t        adv_state;
  logic [ROM_AW-1:0] adv_index;
  logic [15:0]       rom_data;
  logic [7:0]        ms_count;
  logic [TICK_W-1:0] tick_count;
  logic              first_cycle;
`ifdef OV7670_SOFT_RESET_EN
  logic              prologue;
`endif

  ov7670_config_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_AW    (ROM_AW)
  ) u_rom (
    .clk  (clk),
    .addr (rom_index),
    .data (rom_data)
  );

  assign sccb_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  // Next entry, or finish when the table runs out without an end marker.
  always_comb begin
    adv_state = S_FETCH;
    adv_index = rom_index + ROM_AW'(1);
    if (rom_index == ROM_AW'(ROM_DEPTH - 1)) begin
      adv_state = S_FINISH;
      adv_index = rom_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rom_index    <= '0;
      sccb_address <= '0;
      sccb_data    <= '0;
      done         <= 1'b0;
      ms_count     <= '0;
      tick_count   <= '0;
      first_cycle  <= 1'b1;
`ifdef OV7670_SOFT_RESET_EN
      prologue     <= 1'b0;
`endif
    end else begin
      first_cycle <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start || (AUTO_START != 0 && first_cycle)) begin
            rom_index <= '0;
            done      <= 1'b0;
            state     <= S_WAIT_IDLE;
`ifdef OV7670_SOFT_RESET_EN
            prologue  <= 1'b1;
`endif
          end
        end
        // The SCCB engine is not reset with us and may still be finishing.
        S_WAIT_IDLE: begin
          if (sccb_ready) begin
`ifdef OV7670_SOFT_RESET_EN
            sccb_address <= COM7_ADDR;
            sccb_data    <= COM7_SOFT_RESET;
            state        <= S_ISSUE;
`else
            state        <= S_FETCH;
`endif
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (rom_data == CFG_END) begin
            state <= S_FINISH;
          end else if (rom_data[15:8] == CFG_DELAY_TAG) begin
            if (rom_data[7:0] == 8'd0) begin
              state     <= adv_state;
              rom_index <= adv_index;
            end else begin
              ms_count   <= rom_data[7:0];
              tick_count <= TICK_W'(TICKS - 1);
              state      <= S_DELAY;
            end
          end else begin
            sccb_address <= rom_data[15:8];
            sccb_data    <= rom_data[7:0];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_ACCEPT;
        // Engine drops ready one cycle after start; do not re-request here.
        S_WAIT_ACCEPT: if (!sccb_ready) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (sccb_ready) begin
`ifdef OV7670_SOFT_RESET_EN
            if (prologue) begin
              ms_count   <= SOFT_RESET_MS;
              tick_count <= TICK_W'(TICKS - 1);
              state      <= S_DELAY;
            end else begin
              state     <= adv_state;
              rom_index <= adv_index;
            end
`else
            state     <= adv_state;
            rom_index <= adv_index;
`endif
          end
        end
        S_DELAY: begin
          if (tick_count == '0) begin
            if (ms_count <= 8'd1) begin
`ifdef OV7670_SOFT_RESET_EN
              // End of the soft-reset settle: start the table at entry 0.
              if (prologue) begin
                prologue <= 1'b0;
                state    <= S_FETCH;
              end else begin
                state     <= adv_state;
                rom_index <= adv_index;
              end
`else
              state     <= adv_state;
              rom_index <= adv_index;
`endif
            end else begin
              ms_count   <= ms_count - 8'd1;
              tick_count <= TICK_W'(TICKS - 1);
            end
          end else begin
            tick_count <= tick_count - TICK_W'(1);
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Testbench for ov7670_config_sequencer: scoreboard of expected SCCB writes
// (word plus allowed gap since the previous ready rise), checked as each
// sccb_start appears. A second instance with a 4-entry ROM covers the
// missing-end-marker case.
module tb_ov7670_config_sequencer;

  localparam int unsigned ANY  = 32'hFFFF_FFFF;
  localparam int unsigned LAT  = 200;
  localparam int unsigned LAT2 = 20;

  localparam logic [15:0] MAIN_WR [10] = '{16'h3A04, 16'h40D0, 16'h1214, 16'h8C00, 16'h1716,
                                           16'h1804, 16'h3224, 16'h1902, 16'h1A7A, 16'h030A};
  localparam int unsigned GMIN [10] = '{0, 1, 1, 1, 2000, 1, 1, 1, 1, 1};
  localparam int unsigned GMAX [10] = '{ANY, 8, 8, 8, 2010, 10, 8, 8, 8, 8};

  typedef struct {
    logic [15:0] word;
    int unsigned gmin;
    int unsigned gmax;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rst2, cfg_start, hold_low;
  logic       sccb_ready, sccb_start, busy, done;
  logic [7:0] sccb_address, sccb_data;
  logic [6:0] rom_index;
  logic       sccb_ready2, sccb_start2, busy2, done2;
  logic [7:0] sccb_address2, sccb_data2;
  logic [1:0] rom_index2;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, last_rise = 0, n_wr = 0, n_wr2 = 0;
  exp_t        q_main[$];
  logic [15:0] q_rom4[$];
  logic        in_xfer = 1'b0, rdy_prev = 1'b0;
  logic [15:0] cur_word = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ov7670_config_sequencer #(
    .CLK_FREQ (1000000), .ROM_DEPTH (128), .ROM_AW (7), .AUTO_START (1)
  ) dut (
    .clk (clk), .rst (rst), .cfg_start (cfg_start), .sccb_ready (sccb_ready),
    .sccb_start (sccb_start), .sccb_address (sccb_address), .sccb_data (sccb_data),
    .busy (busy), .done (done), .rom_index (rom_index)
  );

  ov7670_config_sequencer #(
    .CLK_FREQ (1000000), .ROM_DEPTH (4), .ROM_AW (2), .AUTO_START (1)
  ) dut4 (
    .clk (clk), .rst (rst2), .cfg_start (1'b0), .sccb_ready (sccb_ready2),
    .sccb_start (sccb_start2), .sccb_address (sccb_address2), .sccb_data (sccb_data2),
    .busy (busy2), .done (done2), .rom_index (rom_index2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SCCB engine models: ready falls the cycle after an accepted start and
  // returns after the transaction latency. No reset, like the real engine.
  logic m_ready = 1'b1, m_ready2 = 1'b1;
  int unsigned m_cnt = 0, m_cnt2 = 0;
  assign sccb_ready  = m_ready && !hold_low;
  assign sccb_ready2 = m_ready2;

  always @(posedge clk) begin
    if (sccb_ready && sccb_start === 1'b1) begin
      m_ready <= 1'b0;
      m_cnt   <= LAT;
    end else if (!m_ready) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else            m_cnt   <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (sccb_ready2 && sccb_start2 === 1'b1) begin
      m_ready2 <= 1'b0;
      m_cnt2   <= LAT2;
    end else if (!m_ready2) begin
      if (m_cnt2 == 0) m_ready2 <= 1'b1;
      else             m_cnt2   <= m_cnt2 - 1;
    end
  end

  // Scoreboard monitor, main instance
  always @(negedge clk) begin : mon_main
    exp_t e;
    int unsigned gap;
    if (!rst) begin
      if (sccb_start === 1'b1) begin
        check("start_while_ready", sccb_ready, 1);
        n_wr++;
        in_xfer  = 1'b1;
        cur_word = {sccb_address, sccb_data};
        if (q_main.size() == 0) begin
          check($sformatf("extra_write_%h", cur_word), 0, 1);
        end else begin
          e   = q_main.pop_front();
          gap = cyc - last_rise;
          check("wr_word", cur_word, e.word);
          check($sformatf("wr_gap_%0d_range_%0d_%0d", gap, e.gmin, e.gmax),
                (gap >= e.gmin && gap <= e.gmax), 1);
        end
      end
      if (sccb_ready && !rdy_prev) begin
        last_rise = cyc;
        if (in_xfer) begin
          check("hold_stable", {sccb_address, sccb_data}, cur_word);
          in_xfer = 1'b0;
        end
      end
    end
    rdy_prev = sccb_ready;
  end

  // Scoreboard monitor, 4-entry ROM instance
  always @(negedge clk) begin : mon_rom4
    if (!rst2 && sccb_start2 === 1'b1) begin
      check("r4_start_while_ready", sccb_ready2, 1);
      n_wr2++;
      if (q_rom4.size() == 0) check("r4_extra_write", 0, 1);
      else check("r4_wr_word", {sccb_address2, sccb_data2}, q_rom4.pop_front());
    end
  end

  task automatic push_pass();
    exp_t e;
`ifdef OV7670_SOFT_RESET_EN
    e.word = 16'h1280; e.gmin = 0; e.gmax = ANY;
    q_main.push_back(e);
`endif
    for (int i = 0; i < 10; i++) begin
      e.word = MAIN_WR[i]; e.gmin = GMIN[i]; e.gmax = GMAX[i];
`ifdef OV7670_SOFT_RESET_EN
      if (i == 0) begin e.gmin = 10000; e.gmax = 10010; end
`endif
      q_main.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30000 && !(done && !busy); i++) @(negedge clk);
    check(tag, done, 1);
  endtask

  task automatic wait_writes(input int unsigned target, input string tag);
    for (int i = 0; i < 30000 && n_wr < target; i++) @(negedge clk);
    check(tag, n_wr >= target, 1);
  endtask

  initial begin : main
    int unsigned base;
    logic [6:0]  idx;
    logic        prev;
    rst = 1'b1; rst2 = 1'b1; cfg_start = 1'b0; hold_low = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_start", sccb_start, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_index", rom_index, 0);
    check("rst_addr",  sccb_address, 0);
    check("rst_data",  sccb_data, 0);

    // Pass A: auto start with the engine not ready for 50 cycles
    push_pass();
    q_rom4.delete();
`ifdef OV7670_SOFT_RESET_EN
    q_rom4.push_back(16'h1280);
`endif
    q_rom4.push_back(16'h3A04); q_rom4.push_back(16'h40D0);
    q_rom4.push_back(16'h1214); q_rom4.push_back(16'h8C00);
    rst = 1'b0; rst2 = 1'b0;
    repeat (50) @(negedge clk);
    check("hold_no_start", n_wr, 0);
    check("hold_busy", busy, 1);
    check("hold_index", rom_index, 0);
    hold_low = 1'b0;
    wait_done("passA_done");
    check("passA_busy", busy, 0);
    check("passA_left", q_main.size(), 0);

    // Pass B: cfg_start; a mid-pass pulse and one coinciding with done are ignored
    repeat (5) @(negedge clk);
    push_pass();
    base = n_wr;
    cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    check("passB_done_clr", done, 0);
    check("passB_busy", busy, 1);
    wait_writes(base + 3, "passB_reach3");
    repeat (10) @(negedge clk);
    idx = rom_index;
    cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    @(negedge clk);
    check("midpass_cfg_index", rom_index, idx);
    check("midpass_cfg_busy", busy, 1);
    for (int i = 0; i < 30000 && q_main.size() != 0; i++) @(negedge clk);
    prev = sccb_ready;
    for (int i = 0; i < 1000 && !(sccb_ready && !prev); i++) begin
      prev = sccb_ready;
      @(negedge clk);
    end
    // Final ready rise seen; done is set on the fourth edge after it.
    repeat (3) @(posedge clk);
    #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    check("cfg_on_done_done", done, 1);
    check("cfg_on_done_busy", busy, 0);
    check("passB_left", q_main.size(), 0);

    // Pass C: reset during the second write, auto restart
    @(negedge clk);
    push_pass();
    base = n_wr;
    cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    wait_writes(base + 2, "passC_reach2");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_start", sccb_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_index", rom_index, 0);
    @(negedge clk);
    rst = 1'b0;
    q_main.delete();
    in_xfer = 1'b0;
    push_pass();
    wait_done("restart_done");
    check("restart_busy", busy, 0);
    check("restart_left", q_main.size(), 0);

    // No end marker in a 4-entry ROM
    for (int i = 0; i < 30000 && !done2; i++) @(negedge clk);
    check("r4_done", done2, 1);
    check("r4_busy", busy2, 0);
    check("r4_left", q_rom4.size(), 0);
`ifdef OV7670_SOFT_RESET_EN
    check("r4_writes", n_wr2, 5);
`else
    check("r4_writes", n_wr2, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
Upstream feeder for the SCCB write engine. Walks a ROM of OV7670 register/value pairs and hands each pair to the SCCB engine over its start/ready handshake. Executes embedded millisecond delay entries and stops at an end marker. Sits between top-level camera bring-up control and the SCCB interface; raises done once the camera is fully configured.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz; one delay tick = CLK_FREQ/1000 cycles (1 ms)
ROM_DEPTH, 128, number of 16-bit ROM entries
ROM_AW, 7, ROM address width, clog2(ROM_DEPTH)
AUTO_START, 1, 1 = start one configuration pass automatically on the first cycle after rst deasserts

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cfg_start  input  1  single-cycle pulse; starts a configuration pass from ROM entry 0
sccb_ready  input  1  SCCB engine idle/ready
sccb_start  output  1  single-cycle request to the SCCB engine
sccb_address  output  8  camera register address; held stable from sccb_start until the write completes
sccb_data  output  8  register value; held like sccb_address
busy  output  1  configuration pass in progress
done  output  1  sticky; set at the end of a pass, cleared by rst or a new pass
rom_index  output  ROM_AW  index of the ROM entry currently being processed

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: sccb_start=0, sccb_address=0, sccb_data=0, busy=0, done=0, rom_index=0, delay counters=0, state=IDLE.
- ROM entry format, 16 bits {hi,lo}:
  - 16'hFFFF = END.
  - hi=8'hF0 = DELAY of lo ms; lo=0 is a no-op.
  - Anything else = WRITE register hi with value lo.
- ROM read is synchronous with 1-cycle latency.
- States:
  - IDLE: busy=0. Leave on cfg_start, or on the first post-reset cycle if AUTO_START=1. On leaving: rom_index<=0, done<=0, go to WAIT_IDLE.
  - WAIT_IDLE: wait for sccb_ready=1. The SCCB engine has no reset and may be mid-transaction after a sequencer reset. Then go to FETCH.
  - FETCH: issue ROM address; go to DECODE next cycle.
  - DECODE:
    - END -> FINISH.
    - DELAY -> DELAY state with ms_count<=lo and tick_count<=CLK_FREQ/1000-1.
    - WRITE -> latch sccb_address/sccb_data, go to ISSUE.
  - ISSUE: sccb_start=1 for exactly one cycle; go to WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for sccb_ready=0. The SCCB engine drops ready one cycle after seeing start, so sccb_start must not be reasserted here. Then go to WAIT_DONE.
  - WAIT_DONE: wait for sccb_ready=1, then advance.
  - DELAY: tick_count counts down to 0. At 0: if ms_count<=1, advance; else ms_count-1 and reload tick_count.
  - Advance: if rom_index==ROM_DEPTH-1, go to FINISH (missing END marker tolerated); else rom_index+1 and go to FETCH.
  - FINISH: done<=1; go to IDLE.
- busy=1 in every state except IDLE.
- cfg_start while busy is ignored. cfg_start in the same cycle as done is set is also ignored; a new pass needs a later pulse.
- rst mid-pass: immediate return to reset values. sccb_start drops the same edge. With AUTO_START=1 a fresh pass begins after reset.
- Per-write overhead beyond the SCCB transaction: 5 cycles (FETCH, DECODE, ISSUE, and the accept and done detection cycles).

Optional Feature:
OV7670_SOFT_RESET_EN
- Defined: every pass first writes reg 8'h12 = 8'h80 (COM7 soft reset), then waits 10 ms, then starts at ROM entry 0. rom_index reads 0 throughout this prologue.
- Undefined: the pass starts directly at ROM entry 0 with no prologue.

Decomposition:
- Shared package ov7670_cfg_pkg holds:
  - State enum.
  - Entry-format constants: CFG_END=16'hFFFF, CFG_DELAY_TAG=8'hF0.
  - COM7 address and soft-reset value.
  - Default soft-reset delay (10 ms).
- One sub-module, ov7670_config_rom: synchronous ROM_DEPTH x 16 table containing the register list. Swappable per camera mode.

Test Plan:
- ROM {12:80? no: 8'h3A:04, 8'h40:D0, FFFF}, model ready drops 1 cycle after start and returns 200 cycles later -> exactly two sccb_start pulses with address/data 3A/04 then 40/D0; done=1, busy=0 after the second ready rise.
- Entry F002 between two writes, CLK_FREQ=1000000 -> gap between first ready rise and second sccb_start = 2000 cycles plus decode overhead (within ±5 cycles); F000 adds no delay.
- sccb_ready held 0 at reset deassert for 50 cycles -> no sccb_start until ready=1, then the first write issues.
- rst asserted during WAIT_DONE of the 2nd write -> next edge sccb_start=0, busy=0, done=0. With AUTO_START=1 the pass restarts at entry 0 after ready=1.
- cfg_start pulsed mid-pass, and again after done -> first pulse ignored (no index reset); second pulse clears done and replays the ROM from entry 0.
- ROM with no END marker (all writes, ROM_DEPTH=4) -> 4 writes, then done=1. With OV7670_SOFT_RESET_EN, 12/80 is issued first, followed by a 10 ms gap.
